mac_sequencer: RTL and testbench

Sequences the dot-product run once SRAM A and SRAM B each hold 8 FP16 operands. On start it clears the FP MAC accumulator and walks addresses 0..DEPTH-1, reading both SRAMs through shared active-low controls. Each operand pair goes to the FP MAC datapath over a valid/ready handshake; the block then waits for the final accumulate and latches the result for the hex display / arduino_out path. A drain watchdog flags a hung datapath.

---
 rtl/mac_pkg.sv | 19 +
 rtl/seq_wdog.sv | 27 ++
 rtl/mac_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mac_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: state codes and FP16 constants.
package mac_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Codes are visible on state_out, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRead  = 3'd2,
    StIssue = 3'd3,
    StDrain = 3'd4,
    StDone  = 3'd5
  } state_e;

endpackage

// File: rtl/seq_wdog.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module seq_wdog #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mac_sequencer.sv
// Walks SRAM A/B addresses 0..DEPTH-1, feeds operand pairs to the FP MAC and
// latches the final accumulate; a drain watchdog flags a hung datapath.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_cs_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  input  logic [DATA_W-1:0] i_sram_a_dq,
  input  logic [DATA_W-1:0] i_sram_b_dq,
  output logic              o_mac_clear,
  output logic              o_mac_valid,
  input  logic              i_mac_ready,
  output logic [DATA_W-1:0] o_mac_a,
  output logic [DATA_W-1:0] o_mac_b,
  output logic              o_mac_last,
  input  logic              i_mac_done,
  input  logic [DATA_W-1:0] i_mac_result,
  output logic [DATA_W-1:0] o_result,
  output logic              o_result_valid,
  output logic              o_busy,
  output logic              o_timeout_err,
  output logic [2:0]        o_state_out
);

  localparam int unsigned CNT_MAX = (TIMEOUT > RD_LAT) ? TIMEOUT : RD_LAT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  // Counter expires at zero, so loading N-1 gives N cycles in the state.
  localparam logic [CNT_W-1:0]  RD_LOAD   = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  TO_LOAD   = CNT_W'(TIMEOUT - 1);

  state_e            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_sram_addr;
  logic [DATA_W-1:0] r_mac_a, r_mac_b, r_result;
  logic              r_result_valid, r_timeout_err;

  logic              w_load, w_dec, w_expired, w_last;
  logic [CNT_W-1:0]  w_load_val;
  logic              w_start_run, w_capture, w_addr_inc, w_latch, w_set_err;

  assign w_last = (r_sram_addr == LAST_ADDR);

  seq_wdog #(
    .CNT_W(CNT_W)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_dec     (w_dec),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = RD_LOAD;
    w_dec       = 1'b0;
    w_start_run = 1'b0;
    w_capture   = 1'b0;
    w_addr_inc  = 1'b0;
    w_latch     = 1'b0;
    w_set_err   = 1'b0;
    if (i_abort) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:  if (i_start) w_state_nxt = StClear;
        StClear: begin
          w_start_run = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = StRead;
        end
        StRead: begin
          if (w_expired) begin
            w_capture   = 1'b1;
            w_state_nxt = StIssue;
          end else begin
            w_dec = 1'b1;
          end
        end
        StIssue: begin
          if (i_mac_ready) begin
            w_load = 1'b1;
            if (w_last) begin
              w_load_val  = TO_LOAD;
              w_state_nxt = StDrain;
            end else begin
              w_addr_inc  = 1'b1;
              w_state_nxt = StRead;
            end
          end
        end
        StDrain: begin
          if (i_mac_done) begin
            w_latch     = 1'b1;
            w_state_nxt = StDone;
          end else if (w_expired) begin
            w_set_err   = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_dec = 1'b1;
          end
        end
        StDone:  if (i_start) w_state_nxt = StClear;
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // All strobes are already suppressed under abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= StIdle;
      r_sram_addr    <= '0;
      r_mac_a        <= '0;
      r_mac_b        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_abort) begin
        r_sram_addr    <= '0;
        r_result_valid <= 1'b0;
      end
      if (w_start_run) begin
        r_sram_addr    <= '0;
        r_result_valid <= 1'b0;
        r_timeout_err  <= 1'b0;
      end
      if (w_addr_inc) r_sram_addr <= r_sram_addr + 1'b1;
      if (w_capture) begin
        r_mac_a <= i_sram_a_dq;
        r_mac_b <= i_sram_b_dq;
      end
      if (w_latch) begin
        r_result       <= i_mac_result;
        r_result_valid <= 1'b1;
      end
      if (w_set_err) r_timeout_err <= 1'b1;
    end
  end

  assign o_sram_addr    = r_sram_addr;
  assign o_sram_cs_n    = (r_state != StRead);
  assign o_sram_oe_n    = (r_state != StRead);
  assign o_sram_we_n    = 1'b1;
  assign o_mac_clear    = (r_state == StClear);
  assign o_mac_valid    = (r_state == StIssue);
  assign o_mac_last     = (r_state == StIssue) && w_last;
  assign o_mac_a        = r_mac_a;
  assign o_mac_b        = r_mac_b;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_timeout_err  = r_timeout_err;
  assign o_busy         = (r_state == StClear) || (r_state == StRead) ||
                          (r_state == StIssue) || (r_state == StDrain);
  assign o_state_out    = r_state;

endmodule

// File: tb/tb_mac_sequencer.sv
// Two sequencers (RD_LAT=1 and RD_LAT=3) run shared stimulus; each is checked
// every cycle against a behavioural model, plus directed literal expectations.
module tb_mac_sequencer;
  import mac_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, mac_ready = 1'b1;
  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_chk = 0, n_err = 0;
  logic [15:0] mem_a [DEPTH];
  logic [15:0] mem_b [DEPTH];
  int          stub_delay = 2;  // 0 = MAC never finishes
  logic [15:0] stub_res = 16'h4C00;
  bit          spur_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int RDL  = (g == 0) ? 1 : 3;
    localparam int TOUT = (g == 0) ? 255 : 40;

    logic [3:0]  addr;
    logic        cs_n, oe_n, we_n, clr, valid, last, rv, busy, err, mac_done = 1'b0;
    logic [15:0] a_dq = '0, b_dq = '0, mac_a, mac_b, result, mac_result = '0;
    logic [2:0]  st;

    mac_sequencer #(
      .DEPTH(DEPTH), .ADDR_W(4), .DATA_W(16), .RD_LAT(RDL), .TIMEOUT(TOUT)
    ) dut (
      .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
      .o_sram_addr(addr), .o_sram_cs_n(cs_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
      .i_sram_a_dq(a_dq), .i_sram_b_dq(b_dq),
      .o_mac_clear(clr), .o_mac_valid(valid), .i_mac_ready(mac_ready),
      .o_mac_a(mac_a), .o_mac_b(mac_b), .o_mac_last(last),
      .i_mac_done(mac_done), .i_mac_result(mac_result),
      .o_result(result), .o_result_valid(rv), .o_busy(busy),
      .o_timeout_err(err), .o_state_out(st)
    );

    // Model: phase uses the published state codes; m_wait counts cycles in phase.
    int          m_ph = 0, m_addr = 0, m_wait = 0;
    logic [15:0] m_a = '0, m_b = '0, m_res = '0;
    bit          m_rv = 1'b0, m_err = 1'b0;
    bit          s_st, s_ab, s_rdy, s_done, fire, hs_fin = 1'b0;
    logic [15:0] s_res;
    int          scnt = -1, oe_run = 0;
    int          hs_addr[$];
    logic [15:0] hs_a[$], hs_b[$];
    bit          hs_last[$];
    int          hs_edge = 0, clr_cnt = 0, oe_cnt = 0;

    task automatic model_reset();
      m_ph = 0; m_addr = 0; m_wait = 0; m_a = '0; m_b = '0; m_res = '0;
      m_rv = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic [63:0] expv();
      bit iss = (m_ph == 3);
      return {3'(m_ph), 4'(m_addr), m_ph != 2, m_ph != 2, 1'b1, m_ph == 1, iss,
              iss && (m_addr == DEPTH - 1), m_a, m_b, m_res, m_rv,
              (m_ph >= 1 && m_ph <= 4), m_err};
    endfunction

    always begin
      @(posedge clk);
      s_st = start; s_ab = abort; s_rdy = mac_ready; s_done = mac_done; s_res = mac_result;
      if (!rst) model_reset();
      else if (s_ab) begin
        m_ph = 0; m_rv = 1'b0; m_addr = 0; m_wait = 0;
      end else begin
        case (m_ph)
          0: if (s_st) m_ph = 1;
          1: begin m_addr = 0; m_rv = 1'b0; m_err = 1'b0; m_wait = 0; m_ph = 2; end
          2: if (m_wait == RDL - 1) begin
               m_a = mem_a[m_addr]; m_b = mem_b[m_addr]; m_ph = 3;
             end else m_wait++;
          3: if (s_rdy) begin
               m_wait = 0;
               if (m_addr == DEPTH - 1) m_ph = 4;
               else begin m_addr++; m_ph = 2; end
             end
          4: if (s_done) begin m_res = s_res; m_rv = 1'b1; m_ph = 5; end
             else if (m_wait == TOUT - 1) begin m_err = 1'b1; m_ph = 0; end
             else m_wait++;
          5: if (s_st) m_ph = 1;
          default: m_ph = 0;
        endcase
      end
      #1;
      // SRAM: data is garbage until oe_n has been low for RD_LAT cycles.
      if (!oe_n && !cs_n) oe_run++; else oe_run = 0;
      if (oe_run >= RDL) begin
        a_dq = mem_a[addr[2:0]]; b_dq = mem_b[addr[2:0]];
      end else begin
        a_dq = 16'($urandom); b_dq = 16'($urandom);
      end
      // MAC stub: done pulse stub_delay cycles after the last handshake.
      fire = 1'b0;
      if (!rst) scnt = -1;
      else if (hs_fin) begin
        hs_fin = 1'b0;
        scnt = (stub_delay == 0) ? -1 : stub_delay;
      end else if (scnt > 0) begin
        scnt--;
        if (scnt == 0) begin fire = 1'b1; scnt = -1; end
      end
      mac_done   = fire | (spur_en && ($urandom_range(0, 15) == 0));
      mac_result = fire ? stub_res : 16'($urandom);
      @(negedge clk);
      if (!rst) model_reset();
      chk($sformatf("inst%0d_outputs", g),
          {st, addr, cs_n, oe_n, we_n, clr, valid, last, mac_a, mac_b, result, rv, busy, err},
          expv());
      if (valid && mac_ready && !abort && rst) begin
        hs_addr.push_back(int'(addr)); hs_a.push_back(mac_a); hs_b.push_back(mac_b);
        hs_last.push_back(last); hs_edge = ecnt + 1;
        if (last) hs_fin = 1'b1;
      end
      if (clr) clr_cnt++;
      if (!oe_n) oe_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gi[0].hs_addr.delete(); gi[0].hs_a.delete(); gi[0].hs_b.delete(); gi[0].hs_last.delete();
    gi[1].hs_addr.delete(); gi[1].hs_a.delete(); gi[1].hs_b.delete(); gi[1].hs_last.delete();
    gi[0].clr_cnt = 0; gi[0].oe_cnt = 0; gi[1].clr_cnt = 0; gi[1].oe_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int k = 0;
    while ((gi[0].busy || gi[1].busy) && k < lim) begin tick(1); k++; end
    chk({nm, "_bound"}, 64'(k < lim), 64'd1);
  endtask

  // Counts index/operand mismatches in a handshake log of one run.
  function automatic int log_errs(input int g);
    int e = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (g == 0) begin
        if (gi[0].hs_addr[i] != i || gi[0].hs_a[i] != mem_a[i] || gi[0].hs_b[i] != mem_b[i] ||
            gi[0].hs_last[i] != (i == DEPTH - 1)) e++;
      end else begin
        if (gi[1].hs_addr[i] != i || gi[1].hs_a[i] != mem_a[i] || gi[1].hs_b[i] != mem_b[i] ||
            gi[1].hs_last[i] != (i == DEPTH - 1)) e++;
      end
    end
    return e;
  endfunction

  initial begin
    int e0, k, held;
    logic [15:0] prev_res;
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = FP16_ONE; mem_b[i] = 16'h4000; end
    tick(2);
    chk("rst_state", 64'(gi[0].st), 64'd0);
    chk("rst_cs_n", 64'(gi[0].cs_n), 64'd1);
    chk("rst_valid", 64'(gi[0].valid), 64'd0);
    chk("rst_result", 64'(gi[0].result), 64'd0);
    rst = 1'b1; tick(2);

    // 1: all-ones times two, eight pairs -> 16.0
    clear_logs(); e0 = ecnt + 1; pulse_start();
    wait_idle("s1", 300);
    chk("s1_hs_count", 64'(gi[0].hs_addr.size()), 64'd8);
    if (gi[0].hs_addr.size() == 8) chk("s1_log", 64'(log_errs(0)), 64'd0);
    chk("s1_last_edge", 64'(gi[0].hs_edge - e0), 64'd17);
    chk("s1_result", 64'(gi[0].result), 64'h4C00);
    chk("s1_rv", 64'(gi[0].rv), 64'd1);
    chk("s1_clears", 64'(gi[0].clr_cnt), 64'd1);
    chk("s1_oe_cycles_lat1", 64'(gi[0].oe_cnt), 64'd8);
    chk("s1_oe_cycles_lat3", 64'(gi[1].oe_cnt), 64'd24);
    chk("s1_result_lat3", 64'(gi[1].result), 64'h4C00);
    chk("s1_hs_count_lat3", 64'(gi[1].hs_addr.size()), 64'd8);

    // 2: back-pressure for 3 cycles on pair 4
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = 16'($urandom); mem_b[i] = 16'($urandom); end
    stub_res = 16'($urandom);
    clear_logs(); pulse_start();
    held = 0; k = 0;
    while (gi[0].busy && k < 200) begin
      if (gi[0].st == 3'd3 && gi[0].addr == 4'd4 && held < 3) begin
        mac_ready = 1'b0; held++;
        chk("s2_hold_addr", 64'(gi[0].addr), 64'd4);
        chk("s2_hold_a", 64'(gi[0].mac_a), 64'(mem_a[4]));
        chk("s2_hold_valid", 64'(gi[0].valid), 64'd1);
      end else mac_ready = 1'b1;
      tick(1); k++;
    end
    mac_ready = 1'b1;
    wait_idle("s2", 300);
    chk("s2_held", 64'(held), 64'd3);
    chk("s2_hs_count", 64'(gi[0].hs_addr.size()), 64'd8);
    if (gi[0].hs_addr.size() == 8) chk("s2_log", 64'(log_errs(0)), 64'd0);
    chk("s2_hs_count_lat3", 64'(gi[1].hs_addr.size()), 64'd8);
    if (gi[1].hs_addr.size() == 8) chk("s2_log_lat3", 64'(log_errs(1)), 64'd0);
    chk("s2_result", 64'(gi[0].result), 64'(stub_res));
    prev_res = stub_res;

    // 3: abort in ISSUE of pair 5, then a clean rerun
    clear_logs(); pulse_start(); k = 0;
    while (!(gi[0].st == 3'd3 && gi[0].addr == 4'd5) && k < 100) begin tick(1); k++; end
    chk("s3_reach_bound", 64'(k < 100), 64'd1);
    abort = 1'b1; tick(1); abort = 1'b0;
    chk("s3_state", 64'(gi[0].st), 64'd0);
    chk("s3_valid", 64'(gi[0].valid), 64'd0);
    chk("s3_cs_n", 64'(gi[0].cs_n), 64'd1);
    chk("s3_rv", 64'(gi[0].rv), 64'd0);
    chk("s3_result_kept", 64'(gi[0].result), 64'(prev_res));
    clear_logs(); pulse_start();
    chk("s3_clear", 64'(gi[0].clr), 64'd1);
    chk("s3_addr0", 64'(gi[0].addr), 64'd0);
    wait_idle("s3", 300);
    chk("s3_hs_count", 64'(gi[0].hs_addr.size()), 64'd8);
    if (gi[0].hs_addr.size() == 8) chk("s3_log", 64'(log_errs(0)), 64'd0);

    // 4: MAC never completes -> watchdog
    stub_delay = 0; clear_logs(); pulse_start(); k = 0;
    while (gi[0].st != 3'd4 && k < 100) begin tick(1); k++; end
    e0 = ecnt; k = 0;
    while (!gi[0].err && k < 400) begin tick(1); k++; end
    chk("s4_err_edge", 64'(ecnt - e0), 64'd255);
    chk("s4_state", 64'(gi[0].st), 64'd0);
    chk("s4_rv", 64'(gi[0].rv), 64'd0);
    chk("s4_err_lat3", 64'(gi[1].err), 64'd1);
    wait_idle("s4", 400);
    stub_delay = 2; pulse_start(); wait_idle("s4b", 300);
    chk("s4_err_cleared", 64'(gi[0].err), 64'd0);

    // 6: asynchronous reset mid-READ, then start held high through a run
    pulse_start(); k = 0;
    while (!(gi[0].st == 3'd2 && gi[0].addr == 4'd2) && k < 100) begin tick(1); k++; end
    #2 rst = 1'b0;
    #1;
    chk("s6_state", 64'(gi[0].st), 64'd0);
    chk("s6_cs_oe", 64'({gi[0].cs_n, gi[0].oe_n}), 64'd3);
    chk("s6_addr", 64'(gi[0].addr), 64'd0);
    chk("s6_mac_a", 64'(gi[0].mac_a), 64'd0);
    chk("s6_result", 64'(gi[0].result), 64'd0);
    chk("s6_busy", 64'(gi[0].busy), 64'd0);
    tick(1); rst = 1'b1; tick(1);
    clear_logs(); start = 1'b1; k = 0;
    while (gi[0].st != 3'd4 && k < 100) begin tick(1); k++; end
    start = 1'b0;
    wait_idle("s6", 300);
    chk("s6_clears", 64'(gi[0].clr_cnt), 64'd1);
    chk("s6_hs_count", 64'(gi[0].hs_addr.size()), 64'd8);

    // Random traffic; the per-cycle model comparison does the checking.
    for (int i = 0; i < DEPTH; i++) begin mem_a[i] = 16'($urandom); mem_b[i] = 16'($urandom); end
    spur_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 63) == 0);
      mac_ready  = ($urandom_range(0, 3) != 0);
      stub_delay = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 4));
      stub_res   = 16'($urandom);
      tick(1);
    end
    start = 1'b0; abort = 1'b0; mac_ready = 1'b1; spur_en = 1'b0;
    wait_idle("rand_end", 600);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
